// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared definitions for the clock divider.
//   state_t  : divider run state (IDLE, RUN, DRAIN)
//   DIV_MIN  : smallest divisor the block will accept
//   half_up  : ceil(n/2), used for the high portion of div_clk
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam int unsigned DIV_MIN = 2;

    // Computed one bit wider than the operand so that the largest divisor
    // value does not overflow when 1 is added.
    function automatic logic [32:0] half_up(input logic [31:0] n);
        return ({1'b0, n} + 33'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_gen.sv
// clk_div_gen: divided clock-enable tick and glitch-free divided clock.
//
// Ports:
//   clk        in   fast clock, the only clock
//   reset      in   asynchronous, active-high reset
//   en         in   run request (level)
//   cfg_valid  in   new divisor offered
//   cfg_div    in   offered divisor (DIV_W bits)
//   cfg_ready  out  a divisor can be accepted (no divisor pending)
//   cfg_err    out  one-cycle pulse when a divisor below DIV_MIN is rejected
//   div_clk    out  divided clock, high for ceil(N/2) of every N cycles
//   tick       out  one-cycle pulse at the start of each divided period
//   tick_count out  number of ticks issued, wraps (CNT_W bits)
//   running    out  a divided period is in progress
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 4,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             div_clk,
    output logic             tick,
    output logic [CNT_W-1:0] tick_count,
    output logic             running
);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] phase_q, phase_d;
    logic [DIV_W-1:0] n_q, n_d;
    logic [DIV_W-1:0] pend_div_q;
    logic             pend_q;
    logic             at_wrap;
    logic             apply_pend;
    logic             cfg_fire;
    logic             cfg_bad;
    logic             tick_d;
    logic             div_clk_d;
    logic             running_d;

    assign cfg_ready  = ~pend_q;
    assign cfg_fire   = cfg_valid & ~pend_q;
    assign cfg_bad    = (cfg_div < DIV_W'(DIV_MIN));
    assign at_wrap    = (state_q != IDLE) && (phase_q == n_q - DIV_W'(1));
    // A pending divisor only replaces N between periods, so a period is never
    // stretched or cut short by reprogramming.
    assign apply_pend = pend_q && ((state_q == IDLE) || at_wrap);
    assign n_d        = apply_pend ? pend_div_q : n_q;

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            n_q        <= DIV_W'(DEFAULT_DIV);
            pend_q     <= 1'b0;
            pend_div_q <= '0;
            tick       <= 1'b0;
            div_clk    <= 1'b0;
            running    <= 1'b0;
            tick_count <= '0;
            cfg_err    <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            n_q     <= n_d;
            tick    <= tick_d;
            div_clk <= div_clk_d;
            running <= running_d;
            cfg_err <= cfg_fire & cfg_bad;
            if (tick_d) begin
                tick_count <= tick_count + CNT_W'(1);
            end
            if (apply_pend) begin
                pend_q <= 1'b0;
            end
            if (cfg_fire && !cfg_bad) begin
                pend_q     <= 1'b1;
                pend_div_q <= cfg_div;
            end
        end
    end

    // Next state and phase. Dropping en only ends the run at a period
    // boundary; raising it again during DRAIN simply continues the period.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: begin
                phase_d = '0;
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN, DRAIN: begin
                if (at_wrap) begin
                    phase_d = '0;
                    state_d = en ? RUN : IDLE;
                end else begin
                    phase_d = phase_q + DIV_W'(1);
                    state_d = en ? RUN : DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next phase so they can be registered and
    // still line up with the phase they describe.
    always_comb begin
        tick_d    = 1'b0;
        div_clk_d = 1'b0;
        running_d = 1'b0;
        if (state_d != IDLE) begin
            running_d = 1'b1;
            tick_d    = (phase_d == '0);
            div_clk_d = ({1'b0, 32'(phase_d)} < half_up(32'(n_d)));
        end
    end

endmodule

// File: tb/tb_clk_div_gen.sv
module tb_clk_div_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [15:0] cfg_div = 16'd0;

    logic        cfg_ready, cfg_err, div_clk, tick, running;
    logic [31:0] tick_count;
    logic        cfg_ready_w4, cfg_err_w4, div_clk_w4, tick_w4, running_w4;
    logic [3:0]  tick_count_w4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clk_div_gen #(.DIV_W(16), .DEFAULT_DIV(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err), .div_clk(div_clk), .tick(tick),
        .tick_count(tick_count), .running(running)
    );

    // Narrow tick counter instance sharing all stimulus, for the wrap case.
    clk_div_gen #(.DIV_W(16), .DEFAULT_DIV(4), .CNT_W(4)) dut_w4 (
        .clk(clk), .reset(reset), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
        .cfg_ready(cfg_ready_w4), .cfg_err(cfg_err_w4), .div_clk(div_clk_w4), .tick(tick_w4),
        .tick_count(tick_count_w4), .running(running_w4)
    );

    // Reference model: a period is either active or not, with a position
    // inside it; N only changes at a period boundary.
    typedef struct {
        bit          active;
        int unsigned pos;
        int unsigned n;
        bit          pend;
        int unsigned pend_val;
        bit          err;
        bit [31:0]   cnt;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.active = 0; r.pos = 0; r.n = 4; r.pend = 0; r.pend_val = 0; r.err = 0; r.cnt = 0;
        return r;
    endfunction

    function automatic model_t model_step(input model_t s, input logic e, input logic v,
                                          input logic [15:0] d);
        model_t      r;
        bit          boundary;
        int unsigned next_n;
        r        = s;
        boundary = !s.active || (s.pos == s.n - 1);
        next_n   = s.n;
        if (s.pend && boundary) begin
            next_n = s.pend_val;
            r.pend = 0;
        end
        r.err = 0;
        if (v && !s.pend) begin
            if (d < 16'd2) r.err = 1;
            else begin
                r.pend     = 1;
                r.pend_val = int'(d);
            end
        end
        if (boundary) begin
            r.active = e;
            r.pos    = 0;
        end else begin
            r.pos = s.pos + 1;
        end
        r.n = next_n;
        if (r.active && r.pos == 0) r.cnt = s.cnt + 32'd1;
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= model_reset();
        else       m <= model_step(m, en, cfg_valid, cfg_div);
    end

    function automatic logic [45:0] dut_vec();
        return {div_clk, tick, running, cfg_ready, cfg_err, tick_count,
                div_clk_w4, tick_w4, running_w4, cfg_ready_w4, cfg_err_w4, tick_count_w4};
    endfunction

    function automatic logic [45:0] exp_vec(input model_t s);
        logic [4:0]  f;
        logic [31:0] c;
        f = {s.active && (s.pos < (s.n + 1) / 2), s.active && (s.pos == 0), s.active, !s.pend, s.err};
        c = s.cnt;
        return {f, c, f, c[3:0]};
    endfunction

    task automatic program_div(input logic [15:0] val);
        cfg_valid = 1'b1;
        cfg_div   = val;
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic stop_to_idle(input string name);
        en = 1'b0;
        checks++;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!running) return;
        end
        failures++;
        $display("FAIL %s_drain_timeout running=%b required=0", name, running);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++;
        if (dut_vec() !== {5'b00010, 32'd0, 5'b00010, 4'd0}) begin
            failures++;
            $display("FAIL reset_values got=%h required=%h", dut_vec(), {5'b00010, 32'd0, 5'b00010, 4'd0});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_default_run();
        en = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== exp_vec(m)) begin
                failures++;
                $display("FAIL default_model t=%0d got=%h required=%h", t, dut_vec(), exp_vec(m));
            end
            checks++;
            if (tick !== (t % 4 == 0) || div_clk !== (t % 4 < 2)) begin
                failures++;
                $display("FAIL default_wave t=%0d tick=%b div_clk=%b required tick=%b div_clk=%b",
                         t, tick, div_clk, (t % 4 == 0), (t % 4 < 2));
            end
        end
        checks++;
        if (tick_count !== 32'd10) begin
            failures++;
            $display("FAIL default_tick_count got=%0d required=10", tick_count);
        end
        stop_to_idle("default");
    endtask

    task automatic test_odd_divisor();
        program_div(16'd5);
        en = 1'b1;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== exp_vec(m)) begin
                failures++;
                $display("FAIL odd_model t=%0d got=%h required=%h", t, dut_vec(), exp_vec(m));
            end
            checks++;
            if (tick !== (t % 5 == 0) || div_clk !== (t % 5 < 3)) begin
                failures++;
                $display("FAIL odd_wave t=%0d tick=%b div_clk=%b required tick=%b div_clk=%b",
                         t, tick, div_clk, (t % 5 == 0), (t % 5 < 3));
            end
        end
        stop_to_idle("odd");
    endtask

    task automatic test_midrun_reprogram();
        logic exp_tick, exp_ready;
        program_div(16'd4);
        en = 1'b1;
        for (int t = 0; t < 26; t++) begin
            @(negedge clk);
            exp_tick  = (t == 0 || t == 4 || t == 11 || t == 18 || t == 25);
            exp_ready = !(t == 2 || t == 3);
            checks++;
            if (dut_vec() !== exp_vec(m)) begin
                failures++;
                $display("FAIL midrun_model t=%0d got=%h required=%h", t, dut_vec(), exp_vec(m));
            end
            checks++;
            if (tick !== exp_tick || cfg_ready !== exp_ready) begin
                failures++;
                $display("FAIL midrun_handshake t=%0d tick=%b cfg_ready=%b required tick=%b cfg_ready=%b",
                         t, tick, cfg_ready, exp_tick, exp_ready);
            end
            if (t == 1) begin
                cfg_valid = 1'b1;
                cfg_div   = 16'd7;
            end
            if (t == 2) cfg_valid = 1'b0;
        end
        stop_to_idle("midrun");
    endtask

    task automatic test_illegal();
        program_div(16'd4);
        for (int t = 0; t < 3; t++) begin
            cfg_valid = (t < 2);
            cfg_div   = 16'(t);
            @(negedge clk);
            checks++;
            if (cfg_err !== (t < 2) || cfg_ready !== 1'b1 || dut_vec() !== exp_vec(m)) begin
                failures++;
                $display("FAIL illegal_err t=%0d cfg_err=%b cfg_ready=%b required cfg_err=%b cfg_ready=1",
                         t, cfg_err, cfg_ready, (t < 2));
            end
        end
        en = 1'b1;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            checks++;
            if (tick !== (t % 4 == 0) || cfg_ready !== 1'b1 || dut_vec() !== exp_vec(m)) begin
                failures++;
                $display("FAIL illegal_keeps_n t=%0d tick=%b cfg_ready=%b required tick=%b cfg_ready=1",
                         t, tick, cfg_ready, (t % 4 == 0));
            end
        end
        stop_to_idle("illegal");
    endtask

    task automatic test_graceful_stop();
        program_div(16'd6);
        en = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            checks++;
            if (running !== (t <= 5) || tick !== (t == 0) || div_clk !== (t < 3)
                || dut_vec() !== exp_vec(m)) begin
                failures++;
                $display("FAIL stop_drain t=%0d running=%b tick=%b div_clk=%b required running=%b tick=%b div_clk=%b",
                         t, running, tick, div_clk, (t <= 5), (t == 0), (t < 3));
            end
            if (t == 2) en = 1'b0;
        end
        en = 1'b1;
        for (int t = 0; t < 14; t++) begin
            @(negedge clk);
            checks++;
            if (running !== 1'b1 || tick !== (t % 6 == 0) || div_clk !== (t % 6 < 3)
                || dut_vec() !== exp_vec(m)) begin
                failures++;
                $display("FAIL stop_resume t=%0d running=%b tick=%b div_clk=%b required running=1 tick=%b div_clk=%b",
                         t, running, tick, div_clk, (t % 6 == 0), (t % 6 < 3));
            end
            if (t == 2) en = 1'b0;
            if (t == 4) en = 1'b1;
        end
        stop_to_idle("graceful");
    endtask

    task automatic test_async_reset();
        en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_div   = 16'd9;
        @(negedge clk);
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0 || div_clk !== 1'b1) begin
            failures++;
            $display("FAIL areset_setup cfg_ready=%b div_clk=%b required cfg_ready=0 div_clk=1", cfg_ready, div_clk);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== {5'b00010, 32'd0, 5'b00010, 4'd0}) begin
            failures++;
            $display("FAIL areset_values got=%h required=%h", dut_vec(), {5'b00010, 32'd0, 5'b00010, 4'd0});
        end
        en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b1;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            checks++;
            if (tick !== (t % 4 == 0) || dut_vec() !== exp_vec(m)) begin
                failures++;
                $display("FAIL areset_pending_lost t=%0d tick=%b required=%b", t, tick, (t % 4 == 0));
            end
        end
        stop_to_idle("areset");
    endtask

    task automatic test_random();
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== exp_vec(m)) begin
                failures++;
                $display("FAIL random_model t=%0d got=%h required=%h", t, dut_vec(), exp_vec(m));
            end
            if ($urandom_range(0, 7) == 0) en = ~en;
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_div   = 16'($urandom_range(0, 9));
        end
        cfg_valid = 1'b0;
        stop_to_idle("random");
    endtask

    task automatic test_count_wrap();
        int ticks;
        ticks = 0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        program_div(16'd2);
        en = 1'b1;
        for (int t = 0; t < 100 && ticks < 17; t++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== exp_vec(m)) begin
                failures++;
                $display("FAIL wrap_model t=%0d got=%h required=%h", t, dut_vec(), exp_vec(m));
            end
            if (tick) ticks++;
        end
        checks++;
        if (ticks != 17 || tick_count !== 32'd17 || tick_count_w4 !== 4'd1) begin
            failures++;
            $display("FAIL wrap_count ticks=%0d tick_count=%0d tick_count_w4=%0d required 17/17/1",
                     ticks, tick_count, tick_count_w4);
        end
        stop_to_idle("wrap");
    endtask

    initial begin
        #1;
        test_reset();
        test_default_run();
        test_odd_divisor();
        test_midrun_reprogram();
        test_illegal();
        test_graceful_stop();
        test_async_reset();
        test_random();
        test_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
